par_to_serial_phy: RTL
======================

PAR_TO_SERIAL_PHY -- requirements
Module: par_to_serial_phy

Interface
REQ-001 Parameter: IDLE_CHAR, default 8'hBC, byte transmitted in any frame with no data available.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: data_in  input  8  parallel byte from the upstream 2:1 byte mux.
REQ-005 Port: valid_in  input  1  data_in carries a valid byte.
REQ-006 Port: ready_out  output  1  block can accept a byte this cycle.
REQ-007 Port: serial_out  output  1  serial bit stream, MSB first.
REQ-008 Port: frame_start  output  1  high while serial_out carries bit 7 of a frame.
REQ-009 Port: data_flag  output  1  high for all 8 bits of a frame carrying accepted data; low for IDLE_CHAR frames.

Function
REQ-010 Internal state SHALL comprise: 8-bit shift register, 3-bit bit counter bit_cnt, 8-bit holding register, hold_full flag, data_flag register.
REQ-011 Accept occurs on a rising edge when valid_in=1 and ready_out=1; no other condition loads data.
REQ-012 ready_out SHALL equal (!reset && !hold_full), derived from registers and reset only, independent of valid_in.
REQ-013 serial_out SHALL equal shift register bit 7; frame_start SHALL equal (bit_cnt==0); both driven from registers, no combinational path from data_in.
REQ-014 Non-boundary edge (bit_cnt!=7): shift register shifts left one bit (zero fill), bit_cnt increments; an accepted byte is written to the holding register and hold_full set.
REQ-015 Boundary edge (bit_cnt==7): bit_cnt wraps to 0; shift register loads, in priority order: (a) holding register if hold_full, clearing hold_full, data_flag<=1; (b) data_in if accepted this edge (bypass, holding register untouched), data_flag<=1; (c) IDLE_CHAR, data_flag<=0.
REQ-016 Case (a) and an accept cannot coincide, since ready_out=0 while hold_full=1.
REQ-017 Latency: byte accepted on a boundary edge appears as MSB on serial_out the next cycle; byte accepted on any other edge appears at the start of the next frame, at most 7 cycles later.
REQ-018 Throughput: at most one byte per 8 cycles; a continuously valid source SHALL be backpressured via ready_out, with no byte lost or duplicated.
REQ-019 Frames SHALL be emitted back-to-back every 8 cycles with no gap bits; frame_start SHALL pulse exactly once per 8 cycles after reset.
REQ-020 data_in SHALL be ignored whenever valid_in=0 or ready_out=0.

Reset
REQ-021 With reset=1 at an edge: shift register<=8'h00, bit_cnt<=7, holding register<=8'h00, hold_full<=0, data_flag<=0.
REQ-022 During reset and the first cycle after release: serial_out=0, frame_start=0, data_flag=0, ready_out=0 while reset=1.
REQ-023 The first edge after release is a boundary edge; the first frame starts the following cycle.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard any held byte at that edge; no partial byte is replayed after release.

Verification
REQ-025 Reset, valid_in=0 for 40 cycles -> after the first boundary, serial_out repeats 1,0,1,1,1,1,0,0 per frame; frame_start every 8th cycle; data_flag=0.
REQ-026 Single byte 8'hA5 offered on a boundary cycle -> next cycle starts frame 1,0,1,0,0,1,0,1 with frame_start=1, data_flag=1 for 8 cycles; idle frames follow.
REQ-027 Byte 8'h3C accepted at bit_cnt=2 -> ready_out=0 from the next cycle until the boundary; 0,0,1,1,1,1,0,0 sent in the following frame; ready_out returns to 1 the cycle after the load.
REQ-028 valid_in held high with 8'h01, 8'h02, 8'h03, 8'h04 advanced only on accept -> four consecutive data frames in order, no idle frames between them, exactly four accepts.
REQ-029 Byte 8'hFF held, reset pulsed at bit_cnt=4 -> outputs 0 during reset; after release idle frames only, 8'hFF never appears.
REQ-030 Random valid_in/data over 10k cycles checked against a reference queue model -> serialized data frames match accepted bytes in order; zero mismatches.

Source files
------------

// File: rtl/par_to_serial_phy_if.sv
// ============================================================================
// Module  : par_to_serial_phy_if
// Brief   : Byte handshake and serial output bundle of the serializer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface par_to_serial_phy_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       serial_out;
    logic       frame_start;
    logic       data_flag;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  serial_out,
        input  frame_start,
        input  data_flag
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output serial_out,
        output frame_start,
        output data_flag
    );
endinterface

`default_nettype wire

// File: rtl/par_to_serial_phy.sv
// ============================================================================
// Module  : par_to_serial_phy
// Brief   : 8-bit parallel-to-serial framer, MSB first, idle-char fill.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module par_to_serial_phy #(
    parameter logic [7:0] IDLE_CHAR = 8'hBC
) (
    input  wire logic         clk,
    input  wire logic         reset,
    par_to_serial_phy_if.slave bus
);

    localparam logic [2:0] LAST_BIT = 3'd7;

    logic [7:0] shift_reg;
    logic [7:0] hold_reg;
    logic [2:0] bit_cnt;
    logic       hold_full;
    logic       data_flag_q;

    logic       ready;
    logic       accept;
    logic       boundary;

    assign ready    = !reset && !hold_full;
    assign accept   = bus.valid_in && ready;
    assign boundary = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= 8'h00;
            bit_cnt     <= LAST_BIT;
            hold_reg    <= 8'h00;
            hold_full   <= 1'b0;
            data_flag_q <= 1'b0;
        end else if (boundary) begin
            bit_cnt <= 3'd0;
            // A held byte has priority; an accept cannot coincide with it.
            if (hold_full) begin
                shift_reg   <= hold_reg;
                hold_full   <= 1'b0;
                data_flag_q <= 1'b1;
            end else if (accept) begin
                shift_reg   <= bus.data_in;
                data_flag_q <= 1'b1;
            end else begin
                shift_reg   <= IDLE_CHAR;
                data_flag_q <= 1'b0;
            end
        end else begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            bit_cnt   <= bit_cnt + 3'd1;
            if (accept) begin
                hold_reg  <= bus.data_in;
                hold_full <= 1'b1;
            end
        end
    end

    assign bus.ready_out   = ready;
    assign bus.serial_out  = shift_reg[7];
    assign bus.frame_start = (bit_cnt == 3'd0);
    assign bus.data_flag   = data_flag_q;

endmodule

`default_nettype wire
